// File: rtl/mapping_out_packer.sv
// mapping_out_packer: collects PE-array result bytes into CH-byte channel words,
// buffers complete words in a DEPTH-entry FIFO and offers them downstream over
// a valid/ready handshake. Provides an almost-full hint and a sticky overflow flag.
module mapping_out_packer #(
    parameter int CH    = 12,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [7:0]               i_result,
    input  logic                     i_flush,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [CH*8-1:0]          o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_almost_full,
    output logic                     o_overflow
);

    localparam int W      = CH * 8;
    localparam int LANE_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    // Assembly state
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [W-1:0]      asm_q, asm_d;

    // FIFO state
    logic [W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;

    // Datapath / control
    logic [W-1:0]      asm_word;
    logic              word_complete;
    logic              push;
    logic              pop;
    logic              push_ok;

    // Merge the incoming byte into its lane so a completing or flushed word
    // already carries it on the push edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        asm_word = asm_q;
        for (int k = 0; k < CH; k++) begin
            if (i_valid && (lane_q == LANE_W'(k))) begin
                asm_word[8*k +: 8] = i_result;
            end
        end
    end

    // Push/pop decisions; a rejected push still closes the word.
    always_comb begin
        word_complete = i_valid && (lane_q == LANE_W'(CH - 1));
        push          = word_complete || (i_flush && (i_valid || (lane_q != '0)));
        pop           = (level_q != '0) && i_ready;
        push_ok       = push && ((level_q < LVL_W'(DEPTH)) || pop);
    end

    // Next-state for lane counter, assembly register, pointers, level and overflow.
    always_comb begin
        lane_d     = lane_q;
        asm_d      = asm_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (i_valid) begin
            lane_d = lane_q + LANE_W'(1);
            asm_d  = asm_word;
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (push && !push_ok) overflow_d = 1'b1;
    end

    // Control and assembly registers, cleared by the asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (i_rst) begin
            lane_q     <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write on accepted pushes.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is not reset; o_data is masked while empty, so stale entries never show.
        if (push_ok) mem_q[wr_ptr_q] <= asm_word;
    end

    // Outputs: head word comes straight from storage, stable until popped.
    always_comb begin
        o_valid       = (level_q != '0);
        o_data        = o_valid ? mem_q[rd_ptr_q] : '0;
        o_level       = level_q;
        o_almost_full = (level_q >= LVL_W'(DEPTH - 1));
        o_overflow    = overflow_q;
    end

endmodule

// File: tb/tb_mapping_out_packer.sv
// Directed testbench for mapping_out_packer (CH=12, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mapping_out_packer;

    localparam int CH    = 12;
    localparam int DEPTH = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_valid = 1'b0;
    logic [7:0]     i_result = '0;
    logic           i_flush = 1'b0;
    logic           i_ready = 1'b0;
    logic           o_valid;
    logic [CH*8-1:0] o_data;
    logic [2:0]     o_level;
    logic           o_almost_full;
    logic           o_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    mapping_out_packer #(.CH(CH), .DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_result      (i_result),
        .i_flush       (i_flush),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_level       (o_level),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_valid  = 1'b1;
        i_result = b;
        step();
        i_valid  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] base);
        for (int k = 0; k < CH; k++) send_byte(base + 8'(k));
    endtask

    // Expected word whose lane k holds base+k.
    function automatic logic [CH*8-1:0] mk(input logic [7:0] base);
        logic [CH*8-1:0] r;
        for (int k = 0; k < CH; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, o_valid, 1'b0);
        check({tag, " data"},  o_data, '0);
        check({tag, " level"}, o_level, 3'd0);
        check({tag, " af"},    o_almost_full, 1'b0);
        check({tag, " ovf"},   o_overflow, 1'b0);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 i_rst = 1'b1;
        #1 check_all_zero(tag);
        #1 i_rst = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        #1 check_all_zero("reset");
        step();
        step();
        i_rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // Basic pack
        i_ready = 1'b1;
        for (int k = 1; k <= 11; k++) send_byte(8'(k));
        check("basic no early valid", o_valid, 1'b0);
        send_byte(8'h0C);
        check("basic valid", o_valid, 1'b1);
        check("basic data", o_data, 96'h0C0B0A090807060504030201);
        check("basic level", o_level, 3'd1);
        step();
        check("basic one cycle", o_valid, 1'b0);
        check("basic level drained", o_level, 3'd0);

        // Gapped input
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) check("gap no early valid", o_valid, 1'b0);
            send_byte(8'(k));
            if (k < 12) step();
        end
        check("gap valid", o_valid, 1'b1);
        check("gap data", o_data, 96'h0C0B0A090807060504030201);
        step();
        check("gap drained", o_valid, 1'b0);

        // Flush of a partial word
        for (int k = 0; k < 5; k++) send_byte(8'hA1 + 8'(k));
        check("flush no early valid", o_valid, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("flush valid", o_valid, 1'b1);
        check("flush data", o_data, 96'h0000000000000000_0000_00A5A4A3A2A1);
        step();
        check("flush drained", o_valid, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("empty flush valid", o_valid, 1'b0);
        check("empty flush level", o_level, 3'd0);
        step();
        check("empty flush later", o_valid, 1'b0);

        // Backpressure and overflow
        i_ready = 1'b0;
        send_word(8'h20);
        send_word(8'h40);
        check("bp level 2", o_level, 3'd2);
        check("bp af after 2", o_almost_full, 1'b0);
        send_word(8'h60);
        check("bp level 3", o_level, 3'd3);
        check("bp af after 3", o_almost_full, 1'b1);
        send_word(8'h80);
        check("bp level 4", o_level, 3'd4);
        check("bp ovf after 4", o_overflow, 1'b0);
        send_word(8'hA0);
        check("bp level 5", o_level, 3'd4);
        check("bp ovf after 5", o_overflow, 1'b1);
        i_ready = 1'b1;
        check("bp drain 1", o_data, mk(8'h20));
        step();
        check("bp drain 2", o_data, mk(8'h40));
        step();
        check("bp drain 3", o_data, mk(8'h60));
        step();
        check("bp drain 4", o_data, mk(8'h80));
        step();
        check("bp empty", o_valid, 1'b0);
        check("bp ovf sticky", o_overflow, 1'b1);
        check("bp af clear", o_almost_full, 1'b0);

        // Clear overflow before the next scenario
        i_ready = 1'b0;
        async_reset_pulse("rst clr");

        // Simultaneous push and pop while full
        send_word(8'h20);
        send_word(8'h40);
        send_word(8'h60);
        send_word(8'h80);
        check("full level", o_level, 3'd4);
        for (int k = 0; k < CH - 1; k++) send_byte(8'hC0 + 8'(k));
        i_ready = 1'b1;
        send_byte(8'hCB);
        i_ready = 1'b0;
        check("pp level", o_level, 3'd4);
        check("pp ovf", o_overflow, 1'b0);
        check("pp head", o_data, mk(8'h40));
        i_ready = 1'b1;
        step();
        check("pp out 3", o_data, mk(8'h60));
        step();
        check("pp out 4", o_data, mk(8'h80));
        step();
        check("pp out new", o_data, 96'hCBCAC9C8C7C6C5C4C3C2C1C0);
        step();
        check("pp empty", o_valid, 1'b0);
        check("pp ovf final", o_overflow, 1'b0);

        // Reset mid-word
        for (int k = 0; k < 7; k++) send_byte(8'hE0 + 8'(k));
        async_reset_pulse("rst mid");
        for (int k = 0; k < CH - 1; k++) send_byte(8'h10 + 8'(k));
        check("rm no stale word", o_valid, 1'b0);
        send_byte(8'h1B);
        check("rm valid", o_valid, 1'b1);
        check("rm data", o_data, 96'h1B1A191817161514131211_10);
        step();
        check("rm drained", o_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mapping_out_packer.md
# mapping_out_packer

- Sits directly downstream of the mapping-layer PE array.
- Collects its stream of saturated 8-bit requantised results (one byte per output filter, `o_valid` qualified, no stall capability) into `CH`-byte channel words.
- Buffers complete words in a small FIFO and presents them to the next layer over a valid/ready handshake.
- Raises an almost-full hint so the controller can deassert the array's enable early, and a sticky overflow flag if a word is ever lost.

## Interface

Parameters:

- `CH`, 12: bytes per packed word (output channels per pixel).
- `DEPTH`, 4: FIFO depth in words; power of two, at least 2.

Ports:

- `i_clk` input 1: clock; all logic rising-edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_valid` input 1: byte strobe from the PE array.
- `i_result` input 8: unsigned result byte.
- `i_flush` input 1: close the current partial word.
- `i_ready` input 1: downstream accepts head word.
- `o_valid` output 1: FIFO non-empty; `o_data` is valid.
- `o_data` output `CH*8`: head word; lane k in bits [8k+7:8k].
- `o_level` output `$clog2(DEPTH)+1`: words held.
- `o_almost_full` output 1: `o_level >= DEPTH-1`.
- `o_overflow` output 1: sticky; a completed word was dropped.

## Operation

Lane counter:

- `lane` runs 0..CH-1. Each `i_valid` writes `i_result` into assembly register lane `lane`, then increments `lane`.
- On the byte at lane CH-1, the full word (assembly register plus the incoming byte) is pushed into the FIFO on the same edge. `lane` returns to 0 and the assembly register clears to 0.

Flush:

- `i_flush` with `lane > 0`, or with `i_valid` asserted in the same cycle, pushes the partial word. Unwritten lanes are 0.
- If `i_valid` coincides with `i_flush`, the byte is included before the push.
- `i_flush` with `lane == 0` and `i_valid` low does nothing.
- `i_flush` coinciding with a naturally completed word pushes exactly one word.

Push and pop rules:

- A push is accepted if `o_level < DEPTH`, or if a pop occurs in the same cycle.
- If the push is rejected: the word is discarded, `o_overflow` sets and holds until reset, and the lane counter and assembly register still reset as normal. The FIFO is unchanged.
- Pop occurs when `o_valid && i_ready`.
- Push and pop in the same cycle leave `o_level` unchanged. When empty, a pop is impossible, so there is no bypass: a pushed word appears the next cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `o_level` is a separate counter, not derived from pointer difference.
- The FIFO head is registered, so `o_data` is stable while `o_valid && !i_ready`.

Reset:

- Asynchronous. `lane = 0`, assembly register = 0, pointers = 0, `o_level = 0`.
- `o_valid = 0`, `o_data = 0`, `o_almost_full = 0`, `o_overflow = 0`.
- A reset mid-word discards partial data. No word is emitted for bytes received before reset.

## Timing

- Final byte (or flush) sampled at edge t: the word is in the FIFO after t. `o_valid` rises in the cycle after edge t if the FIFO was empty. Latency is 1 cycle.
- `o_level` and `o_almost_full` reflect pushes and pops of edge t in the following cycle.
- Throughput: one byte per cycle sustained. Worst-case word rate is one word per CH cycles. Downstream must pop at least once per CH cycles to avoid growth.
- The controller must stop the array when `o_almost_full` is seen. The PE pipeline is about 5 cycles deep, so with CH=12 at most one more word arrives; `DEPTH-1` headroom suffices.
- `i_ready` may toggle every cycle. Pop and push are fully independent in the same cycle.

## Test plan

- **Basic pack:** after reset, drive 12 consecutive bytes 0x01..0x0C with `i_ready=1`.
  - `o_valid` is high for one cycle, 1 cycle after the 12th byte.
  - `o_data` = 0x0C0B0A090807060504030201.
  - `o_level` returns to 0.
- **Gapped input:** the same 12 bytes with `i_valid` low on alternate cycles produce an identical word. No output appears before the 12th byte.
- **Flush:** push 5 bytes 0xA1..0xA5, then assert `i_flush` with `i_valid` low.
  - Word = 0xA5A4A3A2A1 in the low 40 bits, upper 56 bits zero.
  - A following flush with no bytes pushed produces nothing.
- **Backpressure and overflow:** with `i_ready=0`, push 5 full words (DEPTH=4).
  - `o_almost_full` is high after word 3.
  - `o_level` = 4, and `o_overflow` rises after word 5.
  - Raising `i_ready` drains words 1-4 in order, one per cycle. `o_overflow` stays 1.
- **Simultaneous push and pop while full:** with `o_level = 4`, complete a word in the same cycle `i_ready=1`.
  - The push is accepted and `o_level` stays 4.
  - `o_overflow` stays 0, and the new word is the 4th to emerge.
- **Reset mid-word:** push 7 bytes, pulse `i_rst` asynchronously, then push 12 bytes 0x10..0x1B.
  - All outputs are 0 during reset.
  - The first word emitted is 0x1B1A...10, with no trace of the earlier bytes.
